// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: trigger/capture controller for the oscilloscope trace renderer.
// Arms on enable and waits for a rising crossing of trig_level (or an auto-mode timeout).
// It then captures H_PIXELS decimated samples into the write bank of a ping-pong RAM.
// The full bank is handed to the display at the next frame_start, and a registered read
// port returns one stored sample per scan column.
module scope_capture_ctrl #(
    parameter int DATA_W       = 12,
    parameter int H_PIXELS     = 800,
    parameter int ADDR_W       = 10,
    parameter int DECIM_W      = 8,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              auto_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DECIM_W-1:0] decim,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] pixel_x,
    output logic [DATA_W-1:0] disp_value,
    output logic              disp_valid,
    output logic [1:0]        state_o,
    output logic              trig_seen
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_FULL    = 2'b11
    } state_t;

    localparam int MEM_DEPTH = 2 * H_PIXELS;
    localparam int MEM_AW    = $clog2(MEM_DEPTH);
    localparam int TO_W      = $clog2(AUTO_TIMEOUT) + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS - 1);
    localparam logic [ADDR_W:0]   H_LIM     = (ADDR_W + 1)'(H_PIXELS);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(AUTO_TIMEOUT - 1);

    // Bank 0 occupies words 0..H_PIXELS-1, bank 1 the next H_PIXELS words.
    function automatic logic [MEM_AW-1:0] mem_idx(input logic bank, input logic [ADDR_W-1:0] a);
        logic [MEM_AW-1:0] base;
        base = bank ? MEM_AW'(H_PIXELS) : '0;
        return base + MEM_AW'(a);
    endfunction

    state_t             state_q;
    logic               wr_bank_q;
    logic               rd_bank_q;
    logic               has_frame_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [DECIM_W-1:0] dec_cnt_q;
    logic [DATA_W-1:0]  prev_sample_q;
    logic [TO_W-1:0]    timeout_cnt_q;
    logic               trig_seen_q;
    logic [DATA_W-1:0]  disp_value_q;
    logic               disp_valid_q;

    logic [DATA_W-1:0]  mem [MEM_DEPTH];

    logic               trig_evt;
    logic               auto_fire;
    logic [DECIM_W-1:0] dec_max;
    logic               dec_hit;
    logic               wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic               rd_in_range;

    // Trigger, timeout and decimation decode from current state and inputs.
    always_comb begin
        trig_evt    = sample_valid && (prev_sample_q < trig_level) && (sample_in >= trig_level);
        auto_fire   = auto_mode && (timeout_cnt_q == TO_MAX);
        // decim of 0 behaves like 1: keep every sample.
        dec_max     = (decim == '0) ? '0 : decim - 1'b1;
        // >= rather than == so lowering decim mid-capture cannot strand the counter.
        dec_hit     = dec_cnt_q >= dec_max;
        rd_in_range = {1'b0, pixel_x} < H_LIM;
    end

    // Write-port control: the entering sample in ARMED lands at address 0, kept samples in CAPTURE at wr_addr.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        if (rst_n && enable && sample_valid) begin
            case (state_q)
                S_ARMED: begin
                    if (trig_evt || auto_fire) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                    end
                end
                S_CAPTURE: begin
                    if (dec_hit && ({1'b0, wr_addr_q} < H_LIM)) begin
                        wr_en_d = 1'b1;
                    end
                end
                default: wr_en_d = 1'b0;
            endcase
        end
    end

    // Capture state machine with bank bookkeeping and the trig_seen pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b1;
            has_frame_q   <= 1'b0;
            wr_addr_q     <= '0;
            dec_cnt_q     <= '0;
            prev_sample_q <= '0;
            timeout_cnt_q <= '0;
            trig_seen_q   <= 1'b0;
        end else begin
            trig_seen_q <= 1'b0;
            if (sample_valid) begin
                prev_sample_q <= sample_in;
            end
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (!enable) begin
                        state_q       <= S_IDLE;
                        timeout_cnt_q <= '0;
                    end else if (sample_valid) begin
                        if (trig_evt || auto_fire) begin
                            state_q       <= S_CAPTURE;
                            wr_addr_q     <= ADDR_W'(1);
                            dec_cnt_q     <= '0;
                            timeout_cnt_q <= '0;
                            trig_seen_q   <= 1'b1;
                        end else if (timeout_cnt_q != TO_MAX) begin
                            // Saturate so enabling auto_mode late still fires on the next sample.
                            timeout_cnt_q <= timeout_cnt_q + 1'b1;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (!enable) begin
                        // Abandon the partial bank; it is never swapped to display.
                        state_q   <= S_IDLE;
                        wr_addr_q <= '0;
                        dec_cnt_q <= '0;
                    end else if (sample_valid) begin
                        if (dec_hit) begin
                            dec_cnt_q <= '0;
                            wr_addr_q <= wr_addr_q + 1'b1;
                            if (wr_addr_q == LAST_ADDR) begin
                                state_q <= S_FULL;
                            end
                        end else begin
                            dec_cnt_q <= dec_cnt_q + 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (frame_start) begin
                        rd_bank_q   <= wr_bank_q;
                        wr_bank_q   <= rd_bank_q;
                        has_frame_q <= 1'b1;
                        wr_addr_q   <= '0;
                        state_q     <= enable ? S_ARMED : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Sample RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem[mem_idx(wr_bank_q, wr_addr_d)] <= sample_in;
        end
    end

    // Registered display read from the display bank only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_value_q <= '0;
            disp_valid_q <= 1'b0;
        end else if (rd_in_range) begin
            disp_value_q <= mem[mem_idx(rd_bank_q, pixel_x)];
            disp_valid_q <= has_frame_q;
        end else begin
            disp_value_q <= '0;
            disp_valid_q <= 1'b0;
        end
    end

    assign disp_value = disp_value_q;
    assign disp_valid = disp_valid_q;
    assign state_o    = state_q;
    assign trig_seen  = trig_seen_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl: trigger, capture, swap, decimation, auto and abort.
module tb_scope_capture_ctrl;

    localparam int DATA_W  = 12;
    localparam int H_PIX   = 800;
    localparam int ADDR_W  = 10;
    localparam int DECIM_W = 8;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              auto_mode;
    logic [DATA_W-1:0] trig_level;
    logic [DECIM_W-1:0] decim;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              frame_start;
    logic [ADDR_W-1:0] pixel_x;
    logic [DATA_W-1:0] disp_value;
    logic              disp_valid;
    logic [1:0]        state_o;
    logic              trig_seen;

    scope_capture_ctrl #(
        .DATA_W(DATA_W), .H_PIXELS(H_PIX), .ADDR_W(ADDR_W),
        .DECIM_W(DECIM_W), .AUTO_TIMEOUT(4096)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .auto_mode(auto_mode),
        .trig_level(trig_level), .decim(decim), .sample_in(sample_in),
        .sample_valid(sample_valid), .frame_start(frame_start), .pixel_x(pixel_x),
        .disp_value(disp_value), .disp_valid(disp_valid), .state_o(state_o),
        .trig_seen(trig_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] d;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int      checks   = 0;
    int      errors   = 0;
    int      trig_cnt = 0;
    int      cap2 [H_PIX];
    int      cap4 [H_PIX];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Outputs are observed 1 time unit after the edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
        if (trig_seen === 1'b1) trig_cnt++;
    endtask

    task automatic send(input int v);
        sample_in    = DATA_W'(v);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic rd(input int x, input logic ev, input int ed);
        rd_exp_t e;
        rd_exp_t got;
        e.v = ev;
        e.d = DATA_W'(ed);
        pixel_x = ADDR_W'(x);
        exp_q.push_back(e);
        tick();
        got = exp_q.pop_front();
        chk($sformatf("disp_valid[x=%0d]", x), 32'(disp_valid), 32'(got.v));
        chk($sformatf("disp_value[x=%0d]", x), 32'(disp_value), 32'(got.d));
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        int k;
        int base_trig;
        for (int x = 0; x < H_PIX; x++) begin
            cap2[x] = (2048 + 16 * x > 4080) ? 4080 : 2048 + 16 * x;
            cap4[x] = (x == 0) ? 3000 : 3000 + ((4 * x) & 255);
        end

        rst_n = 1'b0; enable = 1'b1; auto_mode = 1'b0; trig_level = 12'd2048;
        decim = 8'd1; sample_in = '0; sample_valid = 1'b0; frame_start = 1'b0;
        pixel_x = '0;

        // T1 reset
        tick();
        tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_disp_value", 32'(disp_value), 32'd0);
        chk("rst_trig_seen", 32'(trig_seen), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("armed_after_rst", 32'(state_o), 32'd1);

        // T2 ramp trigger, decim=1
        for (int i = 0; i < 128; i++) send(16 * i);
        chk("t2_pre_trig_state", 32'(state_o), 32'd1);
        chk("t2_pre_trig_cnt", 32'(trig_cnt), 32'd0);
        send(2048);
        chk("t2_trig_pulse", 32'(trig_seen), 32'd1);
        chk("t2_capture_state", 32'(state_o), 32'd2);
        for (int i = 129; i < 927; i++) send((16 * i > 4080) ? 4080 : 16 * i);
        chk("t2_before_last", 32'(state_o), 32'd2);
        send(4080);
        chk("t2_full_state", 32'(state_o), 32'd3);
        send(4080);
        chk("t2_trig_once", 32'(trig_cnt), 32'd1);
        // Nothing shown yet: display bank has no frame.
        rd(0, 1'b0, 0);

        // T3 swap and sweep
        pulse_frame();
        chk("t3_armed_after_swap", 32'(state_o), 32'd1);
        for (int x = 0; x < 806; x++) begin
            if (x < H_PIX) rd(x, 1'b1, cap2[x]);
            else rd(x, 1'b0, 0);
        end

        // T4 decim=4, last write coinciding with frame_start
        decim = 8'd4;
        for (int i = 0; i < 3; i++) send(1000);
        chk("t4_no_trig_low", 32'(state_o), 32'd1);
        send(3000);
        chk("t4_trig_pulse", 32'(trig_seen), 32'd1);
        for (k = 1; k < 3196; k++) send(3000 + (k & 255));
        chk("t4_before_last", 32'(state_o), 32'd2);
        frame_start = 1'b1;
        send(3000 + (3196 & 255));
        frame_start = 1'b0;
        chk("t4_full_state", 32'(state_o), 32'd3);
        rd(0, 1'b1, cap2[0]);
        rd(5, 1'b1, cap2[5]);
        pulse_frame();
        chk("t4_armed_after_swap", 32'(state_o), 32'd1);
        rd(0, 1'b1, cap4[0]);
        rd(1, 1'b1, cap4[1]);
        rd(2, 1'b1, cap4[2]);
        rd(63, 1'b1, cap4[63]);
        rd(799, 1'b1, cap4[799]);
        rd(800, 1'b0, 0);

        // T5 auto-mode timeout
        auto_mode = 1'b1;
        base_trig = trig_cnt;
        for (int i = 0; i < 4095; i++) send(100);
        chk("t5_auto_wait_state", 32'(state_o), 32'd1);
        chk("t5_auto_no_trig", 32'(trig_cnt - base_trig), 32'd0);
        send(100);
        chk("t5_auto_fire_state", 32'(state_o), 32'd2);
        chk("t5_auto_trig_pulse", 32'(trig_seen), 32'd1);
        enable = 1'b0;
        tick();
        chk("t5_abort_auto", 32'(state_o), 32'd0);

        // T5 manual trigger then abort mid-capture
        auto_mode = 1'b0;
        enable = 1'b1;
        tick();
        chk("t5_rearm", 32'(state_o), 32'd1);
        for (int i = 0; i < 5000; i++) send(100);
        chk("t5_no_auto_state", 32'(state_o), 32'd1);
        send(3000);
        chk("t5_manual_trig", 32'(state_o), 32'd2);
        for (int i = 0; i < 10; i++) send(500);
        enable = 1'b0;
        tick();
        chk("t5_abort_idle", 32'(state_o), 32'd0);
        pulse_frame();
        chk("t5_frame_in_idle", 32'(state_o), 32'd0);
        rd(0, 1'b1, cap4[0]);
        rd(1, 1'b1, cap4[1]);
        rd(799, 1'b1, cap4[799]);

        // Reset clears has_frame
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_state", 32'(state_o), 32'd0);
        pixel_x = '0;
        tick();
        chk("rst2_disp_valid", 32'(disp_valid), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
